// File: rtl/pe_array_sequencer.sv
// Sequences a ROWS x COLS PE grid through one matmul tile in WS or OS mode.
// Outputs are registered from the next state; in_valid reaches mac_enable one cycle later.
module pe_array_sequencer #(
   parameter int          ROWS     = 4,
   parameter int          COLS     = 4,
   parameter int          K_W      = 8,
   parameter logic [15:0] CB_LOAD  = 16'h0000,
   parameter logic [15:0] CB_WS    = 16'h0500,
   parameter logic [15:0] CB_OS    = 16'h1400,
   parameter logic [15:0] CB_DRAIN = 16'h0050
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic           cfg_mode,
   input  logic [K_W-1:0] cfg_k,
   input  logic           abort,
   input  logic           in_valid,
   output logic           busy,
   output logic           done,
   output logic           cfg_err,
   output logic [15:0]    ctrl_crossbar,
   output logic [1:0]     mux_sel,
   output logic           mac_enable,
   output logic           accum_clear,
   output logic           output_stationary_enable,
   output logic [3:0]     input_sel,
   output logic           drain_valid
);

   localparam int SKEW = ROWS + COLS - 2;
   localparam int CW   = K_W + $clog2(ROWS + COLS);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_COMPUTE, S_DRAIN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           mode_q, mode_d;
   logic [K_W-1:0] k_q, k_d;
   logic [CW-1:0]  total;

   logic        busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
   logic [15:0] xbar_q, xbar_d;
   logic [1:0]  mux_sel_q, mux_sel_d;
   logic        mac_en_q, mac_en_d, clr_q, clr_d, ose_q, ose_d, drain_q, drain_d;
   logic [3:0]  in_sel_q, in_sel_d;

   assign total = CW'(k_q) + CW'(SKEW);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CW'(1);
      mode_d    = mode_q;
      k_d       = k_q;
      cfg_err_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               if (cfg_k != '0) begin
                  mode_d  = cfg_mode;
                  k_d     = cfg_k;
                  state_d = cfg_mode ? S_CLEAR : S_LOAD;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         S_LOAD:    if (cnt_q == CW'(ROWS - 1)) state_d = S_COMPUTE;
         S_CLEAR:   state_d = S_COMPUTE;
         S_COMPUTE: begin
            // Only cycles the PEs actually saw as enabled count toward k + SKEW.
            cnt_d = cnt_q + CW'(mac_en_q);
            if (mac_en_q && cnt_q == total - CW'(1)) state_d = mode_q ? S_DRAIN : S_DONE;
         end
         S_DRAIN:   if (cnt_q == CW'(ROWS - 1)) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase

      if (abort && state_q != S_IDLE) state_d = S_IDLE;
      if (state_d != state_q) cnt_d = '0;

      busy_d    = (state_d != S_IDLE);
      done_d    = 1'b0;
      xbar_d    = 16'h0000;
      mux_sel_d = 2'b00;
      mac_en_d  = 1'b0;
      clr_d     = 1'b0;
      ose_d     = 1'b0;
      in_sel_d  = 4'b0000;
      drain_d   = 1'b0;

      unique case (state_d)
         S_LOAD: begin
            mac_en_d = 1'b1;
            xbar_d   = CB_LOAD;
         end
         S_CLEAR: begin
            clr_d  = 1'b1;
            xbar_d = CB_OS;
         end
         S_COMPUTE: begin
            mac_en_d = in_valid;
            in_sel_d = 4'b1111;
            ose_d    = mode_d;
            xbar_d   = mode_d ? CB_OS : CB_WS;
         end
         S_DRAIN: begin
            drain_d   = 1'b1;
            mux_sel_d = 2'b11;
            xbar_d    = CB_DRAIN;
         end
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         mode_q    <= 1'b0;
         k_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         xbar_q    <= 16'h0000;
         mux_sel_q <= 2'b00;
         mac_en_q  <= 1'b0;
         clr_q     <= 1'b0;
         ose_q     <= 1'b0;
         in_sel_q  <= 4'b0000;
         drain_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         k_q       <= k_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
         xbar_q    <= xbar_d;
         mux_sel_q <= mux_sel_d;
         mac_en_q  <= mac_en_d;
         clr_q     <= clr_d;
         ose_q     <= ose_d;
         in_sel_q  <= in_sel_d;
         drain_q   <= drain_d;
      end
   end

   assign busy                     = busy_q;
   assign done                     = done_q;
   assign cfg_err                  = cfg_err_q;
   assign ctrl_crossbar            = xbar_q;
   assign mux_sel                  = mux_sel_q;
   assign mac_enable               = mac_en_q;
   assign accum_clear              = clr_q;
   assign output_stationary_enable = ose_q;
   assign input_sel                = in_sel_q;
   assign drain_valid              = drain_q;

endmodule
